// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream
// Description : Converts the read side of an async FIFO (req/empty/data with a
//               one-cycle read latency) into a valid/ready stream. A two-entry
//               skid buffer absorbs the read latency so that throughput is one
//               beat per cycle. m_valid and m_data come only from registers.
//               Optional macro FIFO_RD_STREAM_CNT_EN adds a 16-bit count of
//               delivered beats on port beat_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
   parameter int DAT_BIT   = 8,
   parameter int BUF_DEPTH = 2
) (
   input  logic               rd_clk,
   input  logic               rd_rst,
   output logic               fifo_rd_req,
   input  logic               fifo_rd_empty,
   input  logic [DAT_BIT-1:0] fifo_rd_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [DAT_BIT-1:0] m_data,
   output logic [1:0]         buf_cnt
`ifdef FIFO_RD_STREAM_CNT_EN
  ,output logic [15:0]        beat_cnt
`endif
);

   // Occupancy states of the skid buffer
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] TWO   = 2'd2;

   logic [1:0]         r_cnt;
   logic               r_inflight;
   logic [DAT_BIT-1:0] r_head;
   logic [DAT_BIT-1:0] r_tail;

   logic               w_pop;
   logic               w_push;
   logic [2:0]         w_occ;
   logic               w_rd_req;

   // A read word lands in the buffer the cycle after its request
   assign w_push = r_inflight;
   assign w_pop  = (r_cnt != EMPTY) && m_ready;

   // Occupancy once this cycle's arriving word and departing beat settle;
   // only request when that leaves room for one more word.
   assign w_occ    = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_rd_req = !rd_rst && !fifo_rd_empty && (w_occ < 3'(BUF_DEPTH));

   assign fifo_rd_req = w_rd_req;
   assign m_valid     = (r_cnt != EMPTY);
   assign m_data      = r_head;
   assign buf_cnt     = r_cnt;

   // Track the request issued last cycle, whose data is arriving now
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_rd_req;
      end
   end

   // Occupancy state machine
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         r_cnt <= EMPTY;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_cnt <= (r_cnt == EMPTY) ? ONE : TWO;
            2'b01:   r_cnt <= (r_cnt == TWO) ? ONE : EMPTY;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Head/tail data storage; head is always the oldest word
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_cnt == EMPTY) begin
                  r_head <= fifo_rd_data;
               end else begin
                  r_tail <= fifo_rd_data;
               end
            end
            2'b01: begin
               r_head <= r_tail;
            end
            2'b11: begin
               // With one entry, the arriving word replaces the departing head
               if (r_cnt == ONE) begin
                  r_head <= fifo_rd_data;
               end else begin
                  r_head <= r_tail;
                  r_tail <= fifo_rd_data;
               end
            end
            default: begin
               r_head <= r_head;
            end
         endcase
      end
   end

`ifdef FIFO_RD_STREAM_CNT_EN
   logic [15:0] r_beat_cnt;

   // Delivered-beat counter, wraps naturally at 16 bits
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         r_beat_cnt <= 16'd0;
      end else if (w_pop) begin
         r_beat_cnt <= r_beat_cnt + 16'd1;
      end
   end

   assign beat_cnt = r_beat_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_stream
// Description : Directed self-checking bench for fifo_rd_stream. An upstream
//               FIFO model supplies words; every accepted beat is compared
//               with the word list the bench loaded. Beat counter checks run
//               when FIFO_RD_STREAM_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

   logic       rd_clk = 1'b0;
   logic       rd_rst;
   logic       fifo_rd_req;
   logic       fifo_rd_empty;
   logic [7:0] fifo_rd_data;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic [1:0] buf_cnt;
`ifdef FIFO_RD_STREAM_CNT_EN
   logic [15:0] beat_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Upstream FIFO model
   logic [7:0] mem [0:63];
   int         wp = 0;
   int         rp = 0;
   int         ei = 0;
   int         n_req = 0;
   logic       force_empty = 1'b0;

   fifo_rd_stream #(.DAT_BIT(8), .BUF_DEPTH(2)) u_dut (
      .rd_clk        (rd_clk),
      .rd_rst        (rd_rst),
      .fifo_rd_req   (fifo_rd_req),
      .fifo_rd_empty (fifo_rd_empty),
      .fifo_rd_data  (fifo_rd_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .buf_cnt       (buf_cnt)
`ifdef FIFO_RD_STREAM_CNT_EN
     ,.beat_cnt      (beat_cnt)
`endif
   );

   always #5 rd_clk = ~rd_clk;

   assign fifo_rd_empty = force_empty || (rp == wp);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Read port of the FIFO model: one-cycle read latency, flushed on reset
   always @(posedge rd_clk) begin
      if (rd_rst) begin
         rp <= wp;
      end else if (fifo_rd_req) begin
         fifo_rd_data <= mem[rp % 64];
         rp           <= rp + 1;
      end
   end

   // Count read request pulses
   always @(posedge rd_clk) begin
      if (fifo_rd_req) n_req <= n_req + 1;
   end

   // Scoreboard: each accepted beat must be the next loaded word
   always @(negedge rd_clk) begin
      if (rd_rst) begin
         ei <= wp;
      end else begin
         if (fifo_rd_empty) check("req_when_empty", {31'd0, fifo_rd_req}, 32'd0);
         if (m_valid && m_ready) begin
            check("beat_data", {24'd0, m_data}, {24'd0, mem[ei % 64]});
            ei <= ei + 1;
         end
      end
   end

   task automatic step();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic load(input logic [7:0] d);
      mem[wp % 64] = d;
      wp = wp + 1;
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 300 && (ei != wp || m_valid); k++) step();
      check(tag, ei, wp);
      check({tag, "_valid"}, {31'd0, m_valid}, 32'd0);
   endtask

   initial begin
      int n0;
      rd_rst  = 1'b1;
      m_ready = 1'b0;
      #1;
      check("rst_req",   {31'd0, fifo_rd_req}, 32'd0);
      check("rst_valid", {31'd0, m_valid},     32'd0);
      check("rst_data",  {24'd0, m_data},      32'd0);
      check("rst_cnt",   {30'd0, buf_cnt},     32'd0);
      step();
      step();
      rd_rst = 1'b0;

      // Three words, ready high: back-to-back delivery after two cycles
      m_ready = 1'b1;
      load(8'h11); load(8'h22); load(8'h33);
      #1;
      check("s1_req",    {31'd0, fifo_rd_req}, 32'd1);
      step();
      check("s1_lat_v0", {31'd0, m_valid}, 32'd0);
      step();
      check("s1_v1",     {31'd0, m_valid}, 32'd1);
      check("s1_d0",     {24'd0, m_data},  32'h11);
      step();
      check("s1_d1",     {24'd0, m_data},  32'h22);
      step();
      check("s1_d2",     {24'd0, m_data},  32'h33);
      step();
      check("s1_end_v",  {31'd0, m_valid}, 32'd0);

      // Five words, ready low: exactly two reads, buffer full, head stable
      m_ready = 1'b0;
      n0 = n_req;
      load(8'h41); load(8'h42); load(8'h43); load(8'h44); load(8'h45);
      for (int k = 0; k < 6; k++) step();
      check("s2_reqs",  n_req - n0, 32'd2);
      check("s2_cnt",   {30'd0, buf_cnt}, 32'd2);
      check("s2_valid", {31'd0, m_valid}, 32'd1);
      check("s2_head",  {24'd0, m_data},  32'h41);
      step();
      check("s2_stable", {24'd0, m_data}, 32'h41);
      check("s2_full_req", {31'd0, fifo_rd_req}, 32'd0);
      m_ready = 1'b1;
      drain("s2_drain");

      // Seven words with ready toggling every cycle
      for (int k = 0; k < 7; k++) load(8'h70 + 8'(k));
      for (int k = 0; k < 20; k++) begin
         m_ready = ~m_ready;
         step();
      end
      m_ready = 1'b1;
      drain("s3_drain");

      // Empty flag held high: no reads, no output
      force_empty = 1'b1;
      n0 = n_req;
      for (int k = 0; k < 8; k++) begin
         step();
         check("s4_valid", {31'd0, m_valid}, 32'd0);
      end
      check("s4_reqs", n_req - n0, 32'd0);
      force_empty = 1'b0;

      // Reset with a buffered word and a word in flight
      m_ready = 1'b0;
      load(8'hB1); load(8'hB2); load(8'hB3); load(8'hB4); load(8'hB5);
      step();
      step();
      check("s5_pre_cnt", {30'd0, buf_cnt}, 32'd1);
      rd_rst = 1'b1;
      #1;
      check("s5_req",   {31'd0, fifo_rd_req}, 32'd0);
      check("s5_valid", {31'd0, m_valid},     32'd0);
      check("s5_data",  {24'd0, m_data},      32'd0);
      check("s5_cnt",   {30'd0, buf_cnt},     32'd0);
      step();
      step();
      rd_rst  = 1'b0;
      m_ready = 1'b1;
      load(8'hA5);
      #1;
      check("s5_req_after", {31'd0, fifo_rd_req}, 32'd1);
      step();
      step();
      check("s5_new_v", {31'd0, m_valid}, 32'd1);
      check("s5_new_d", {24'd0, m_data},  32'hA5);
      drain("s5_drain");

`ifdef FIFO_RD_STREAM_CNT_EN
      // 65537 beats after a fresh reset wrap the counter to 1
      rd_rst = 1'b1;
      #1;
      check("cnt_rst", {16'd0, beat_cnt}, 32'd0);
      step();
      rd_rst = 1'b0;
      for (int i = 0; i < 65537; i++) begin
         load(8'(i));
         step();
      end
      drain("cnt_drain");
      check("cnt_wrap", {16'd0, beat_cnt}, 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
